// File: rtl/alu_issue_queue.sv
// Reservation station in front of the single-cycle integer ALU: a compacting,
// age-ordered queue that captures writeback broadcasts and issues the oldest ready micro-op.
module alu_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int ROB_LEN = 16,
  parameter int TAG_W   = 7,
  localparam int ROB_IDX_W = $clog2(ROB_LEN),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [4:0]           disp_opcode,
  input  logic [2:0]           disp_funct3,
  input  logic                 disp_funct7,
  input  logic [TAG_W-1:0]     disp_rs1_tag,
  input  logic [TAG_W-1:0]     disp_rs2_tag,
  input  logic                 disp_rs1_rdy,
  input  logic                 disp_rs2_rdy,
  input  logic [31:0]          disp_rs1_data,
  input  logic [31:0]          disp_rs2_data,
  input  logic [31:0]          disp_imm,
  input  logic [31:0]          disp_pc,
  input  logic [ROB_IDX_W-1:0] disp_rob_idx,
  input  logic [TAG_W-1:0]     disp_rd,
  input  logic                 wb0_valid,
  input  logic                 wb1_valid,
  input  logic [TAG_W-1:0]     wb0_tag,
  input  logic [TAG_W-1:0]     wb1_tag,
  input  logic [31:0]          wb0_data,
  input  logic [31:0]          wb1_data,
  input  logic                 flush,
  output logic                 iss_valid,
  output logic [4:0]           iss_opcode,
  output logic [2:0]           iss_funct3,
  output logic                 iss_funct7,
  output logic [31:0]          iss_rs1_data,
  output logic [31:0]          iss_rs2_data,
  output logic [31:0]          iss_imm,
  output logic [31:0]          iss_pc,
  output logic [ROB_IDX_W-1:0] iss_rob_idx,
  output logic [TAG_W-1:0]     iss_rd,
  output logic [CNT_W-1:0]     count
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [4:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7;
    logic [TAG_W-1:0]     rs1_tag;
    logic                 rs1_rdy;
    logic [31:0]          rs1_data;
    logic [TAG_W-1:0]     rs2_tag;
    logic                 rs2_rdy;
    logic [31:0]          rs2_data;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [TAG_W-1:0]     rd;
  } entry_t;

  // Port 0 has priority when both broadcasts hit the same source.
  function automatic entry_t wake(input entry_t e,
                                  input logic v0, input logic [TAG_W-1:0] t0, input logic [31:0] d0,
                                  input logic v1, input logic [TAG_W-1:0] t1, input logic [31:0] d1);
    entry_t r;
    r = e;
    if (e.valid && !e.rs1_rdy) begin
      if (v0 && (t0 != '0) && (e.rs1_tag == t0)) begin
        r.rs1_rdy  = 1'b1;
        r.rs1_data = d0;
      end else if (v1 && (t1 != '0) && (e.rs1_tag == t1)) begin
        r.rs1_rdy  = 1'b1;
        r.rs1_data = d1;
      end
    end
    if (e.valid && !e.rs2_rdy) begin
      if (v0 && (t0 != '0) && (e.rs2_tag == t0)) begin
        r.rs2_rdy  = 1'b1;
        r.rs2_data = d0;
      end else if (v1 && (t1 != '0) && (e.rs2_tag == t1)) begin
        r.rs2_rdy  = 1'b1;
        r.rs2_data = d1;
      end
    end
    return r;
  endfunction

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           woken [DEPTH+1];
  entry_t           disp_e;
  logic [CNT_W-1:0] count_q, count_d, wr_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             found, issue, accept;

  assign disp_ready = (count_q < CNT_W'(DEPTH));
  assign accept     = disp_valid && disp_ready && !flush;
  assign count      = count_q;

  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        found   = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // With no ready entry sel_idx stays 0, so the outputs show entry 0 (all zero when empty).
  assign issue        = found && !flush;
  assign iss_valid    = issue;
  assign iss_opcode   = ent_q[sel_idx].opcode;
  assign iss_funct3   = ent_q[sel_idx].funct3;
  assign iss_funct7   = ent_q[sel_idx].funct7;
  assign iss_rs1_data = ent_q[sel_idx].rs1_data;
  assign iss_rs2_data = ent_q[sel_idx].rs2_data;
  assign iss_imm      = ent_q[sel_idx].imm;
  assign iss_pc       = ent_q[sel_idx].pc;
  assign iss_rob_idx  = ent_q[sel_idx].rob_idx;
  assign iss_rd       = ent_q[sel_idx].rd;

  always_comb begin
    disp_e          = '0;
    disp_e.valid    = 1'b1;
    disp_e.opcode   = disp_opcode;
    disp_e.funct3   = disp_funct3;
    disp_e.funct7   = disp_funct7;
    disp_e.rs1_tag  = disp_rs1_tag;
    disp_e.rs1_rdy  = disp_rs1_rdy || (disp_rs1_tag == '0);
    disp_e.rs1_data = (disp_rs1_tag == '0) ? 32'd0 : disp_rs1_data;
    disp_e.rs2_tag  = disp_rs2_tag;
    disp_e.rs2_rdy  = disp_rs2_rdy || (disp_rs2_tag == '0);
    disp_e.rs2_data = (disp_rs2_tag == '0) ? 32'd0 : disp_rs2_data;
    disp_e.imm      = disp_imm;
    disp_e.pc       = disp_pc;
    disp_e.rob_idx  = disp_rob_idx;
    disp_e.rd       = disp_rd;
    disp_e = wake(disp_e, wb0_valid, wb0_tag, wb0_data, wb1_valid, wb1_tag, wb1_data);

    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = wake(ent_q[i], wb0_valid, wb0_tag, wb0_data, wb1_valid, wb1_tag, wb1_data);
    end
    woken[DEPTH] = '0;

    // New entry lands just above the post-compaction top.
    wr_idx = count_q - CNT_W'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (issue && (IDX_W'(i) >= sel_idx)) ? woken[i+1] : woken[i];
      if (accept && (wr_idx == CNT_W'(i))) begin
        ent_d[i] = disp_e;
      end
      if (flush) begin
        ent_d[i] = '0;
      end
    end

    count_d = flush ? '0 : (count_q + CNT_W'(accept) - CNT_W'(issue));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: ordering, wakeup, bypass, x0, full, flush, reset.
module tb_alu_issue_queue;

  logic        clk, rst_n;
  logic        disp_valid, disp_ready;
  logic [4:0]  disp_opcode;
  logic [2:0]  disp_funct3;
  logic        disp_funct7;
  logic [6:0]  disp_rs1_tag, disp_rs2_tag;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0] disp_rs1_data, disp_rs2_data, disp_imm, disp_pc;
  logic [3:0]  disp_rob_idx;
  logic [6:0]  disp_rd;
  logic        wb0_valid, wb1_valid;
  logic [6:0]  wb0_tag, wb1_tag;
  logic [31:0] wb0_data, wb1_data;
  logic        flush;
  logic        iss_valid;
  logic [4:0]  iss_opcode;
  logic [2:0]  iss_funct3;
  logic        iss_funct7;
  logic [31:0] iss_rs1_data, iss_rs2_data, iss_imm, iss_pc;
  logic [3:0]  iss_rob_idx;
  logic [6:0]  iss_rd;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  alu_issue_queue #(.DEPTH(4), .ROB_LEN(16), .TAG_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob_idx(disp_rob_idx), .disp_rd(disp_rd),
    .wb0_valid(wb0_valid), .wb1_valid(wb1_valid), .wb0_tag(wb0_tag), .wb1_tag(wb1_tag),
    .wb0_data(wb0_data), .wb1_data(wb1_data), .flush(flush),
    .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_funct3(iss_funct3), .iss_funct7(iss_funct7),
    .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .iss_rob_idx(iss_rob_idx), .iss_rd(iss_rd), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wb0_valid  = 1'b0;
    wb1_valid  = 1'b0;
    flush      = 1'b0;
    wb0_tag = '0; wb1_tag = '0; wb0_data = '0; wb1_data = '0;
  endtask

  task automatic disp(input logic [6:0] t1, input logic r1, input logic [31:0] d1,
                      input logic [6:0] t2, input logic r2, input logic [31:0] d2,
                      input logic [6:0] rd, input logic [3:0] rob);
    disp_valid    = 1'b1;
    disp_opcode   = 5'b01100;
    disp_funct3   = 3'd0;
    disp_funct7   = 1'b0;
    disp_rs1_tag  = t1; disp_rs1_rdy = r1; disp_rs1_data = d1;
    disp_rs2_tag  = t2; disp_rs2_rdy = r2; disp_rs2_data = d2;
    disp_imm      = 32'h10;
    disp_pc       = {23'd0, rd, 2'b00};
    disp_rob_idx  = rob;
    disp_rd       = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    disp(7'd0, 1'b0, 32'd0, 7'd0, 1'b0, 32'd0, 7'd0, 4'd0);
    disp_valid = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_ready", disp_ready, 1);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_rs1", iss_rs1_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic ADD: issues the cycle after it is written, gone the cycle after.
    disp(7'd3, 1'b1, 32'd5, 7'd4, 1'b1, 32'd7, 7'd12, 4'd3);
    step(); idle();
    chk("add_valid", iss_valid, 1);
    chk("add_rs1", iss_rs1_data, 5);
    chk("add_rs2", iss_rs2_data, 7);
    chk("add_rd", iss_rd, 12);
    chk("add_rob", iss_rob_idx, 3);
    chk("add_opc", iss_opcode, 5'b01100);
    chk("add_imm", iss_imm, 32'h10);
    chk("add_pc", iss_pc, 48);
    chk("add_count1", count, 1);
    step();
    chk("add_count0", count, 0);
    chk("add_drained", iss_valid, 0);
    chk("add_empty_rs1", iss_rs1_data, 0);

    // Younger ready op bypasses an older waiting one; wb1 then wakes the older.
    disp(7'd20, 1'b0, 32'hDEAD, 7'd21, 1'b1, 32'd2, 7'd30, 4'd4);
    step();
    chk("ooo_a_wait", iss_valid, 0);
    chk("ooo_count1", count, 1);
    disp(7'd1, 1'b1, 32'h11, 7'd2, 1'b1, 32'h22, 7'd31, 4'd5);
    step(); idle();
    chk("ooo_b_valid", iss_valid, 1);
    chk("ooo_b_rd", iss_rd, 31);
    chk("ooo_b_rs1", iss_rs1_data, 32'h11);
    chk("ooo_count2", count, 2);
    wb1_valid = 1'b1; wb1_tag = 7'd20; wb1_data = 32'h1234;
    step(); idle();
    chk("ooo_a_valid", iss_valid, 1);
    chk("ooo_a_rd", iss_rd, 30);
    chk("ooo_a_rs1", iss_rs1_data, 32'h1234);
    chk("ooo_a_rs2", iss_rs2_data, 2);
    chk("ooo_count_a", count, 1);
    step();
    chk("ooo_count0", count, 0);

    // Fill with four waiting ops; a fifth offered while full is refused.
    for (int k = 0; k < 4; k++) begin
      disp(7'd40, 1'b0, 32'hDEAD, 7'd0, 1'b1, 32'h9, 7'(50 + k), 4'(6 + k));
      step();
      chk("fill_count", count, 32'(k + 1));
    end
    chk("full_ready", disp_ready, 0);
    chk("full_nonissue", iss_valid, 0);
    disp(7'd1, 1'b1, 32'h1, 7'd2, 1'b1, 32'h2, 7'd60, 4'd15);
    wb0_valid = 1'b1; wb0_tag = 7'd40; wb0_data = 32'hA0;
    step(); idle();
    chk("full_count_hold", count, 4);
    chk("full_ready_hold", disp_ready, 0);
    chk("drain0_valid", iss_valid, 1);
    chk("drain0_rd", iss_rd, 50);
    chk("drain0_rs1", iss_rs1_data, 32'hA0);
    chk("drain0_rs2_x0", iss_rs2_data, 0);
    step();
    chk("drain1_count", count, 3);
    chk("drain1_ready", disp_ready, 1);
    chk("drain1_rd", iss_rd, 51);
    chk("drain1_rob", iss_rob_idx, 7);
    step();
    chk("drain2_rd", iss_rd, 52);
    step();
    chk("drain3_rd", iss_rd, 53);
    chk("drain3_count", count, 1);
    step();
    chk("drain_count0", count, 0);
    chk("drain_valid0", iss_valid, 0);

    // Dispatch bypass: wakeup for tag 9 in the dispatch cycle.
    disp(7'd1, 1'b1, 32'h1, 7'd9, 1'b0, 32'h0, 7'd13, 4'd10);
    wb0_valid = 1'b1; wb0_tag = 7'd9; wb0_data = 32'hCAFE;
    step(); idle();
    chk("byp_valid", iss_valid, 1);
    chk("byp_rs2", iss_rs2_data, 32'hCAFE);
    chk("byp_rd", iss_rd, 13);
    step();
    chk("byp_count0", count, 0);

    // x0 source forced to zero and ready; tag-0 broadcasts ignored.
    disp(7'd0, 1'b0, 32'hFFFF, 7'd2, 1'b1, 32'd3, 7'd14, 4'd11);
    wb0_valid = 1'b1; wb0_tag = 7'd0; wb0_data = 32'h5555;
    wb1_valid = 1'b1; wb1_tag = 7'd0; wb1_data = 32'h6666;
    step(); idle();
    chk("x0_valid", iss_valid, 1);
    chk("x0_rs1", iss_rs1_data, 0);
    chk("x0_rs2", iss_rs2_data, 3);
    // Issue and dispatch in the same cycle keep count constant.
    disp(7'd5, 1'b1, 32'h66, 7'd6, 1'b1, 32'h77, 7'd15, 4'd12);
    step(); idle();
    chk("swap_count", count, 1);
    chk("swap_rd", iss_rd, 15);
    chk("swap_rs1", iss_rs1_data, 32'h66);
    step();
    chk("swap_count0", count, 0);

    // Flush with a concurrent dispatch and matching wakeup.
    disp(7'd45, 1'b0, 32'h0, 7'd0, 1'b1, 32'h0, 7'd70, 4'd1);
    step();
    disp(7'd45, 1'b0, 32'h0, 7'd0, 1'b1, 32'h0, 7'd71, 4'd2);
    step();
    disp(7'd3, 1'b1, 32'h1, 7'd0, 1'b1, 32'h0, 7'd72, 4'd3);
    step(); idle();
    chk("fl_pre_count", count, 3);
    chk("fl_pre_valid", iss_valid, 1);
    chk("fl_pre_rd", iss_rd, 72);
    disp(7'd3, 1'b1, 32'h1, 7'd4, 1'b1, 32'h2, 7'd73, 4'd4);
    flush = 1'b1;
    wb0_valid = 1'b1; wb0_tag = 7'd45; wb0_data = 32'hBEEF;
    #1;
    chk("fl_cycle_valid", iss_valid, 0);
    step(); idle(); #1;
    chk("fl_count", count, 0);
    chk("fl_valid", iss_valid, 0);
    chk("fl_ready", disp_ready, 1);
    chk("fl_rd", iss_rd, 0);
    step();
    chk("fl_after_valid", iss_valid, 0);
    chk("fl_after_count", count, 0);

    // Asynchronous reset in the middle of a cycle.
    disp(7'd1, 1'b1, 32'h99, 7'd2, 1'b1, 32'h98, 7'd80, 4'd5);
    step(); idle();
    chk("mr_pre_valid", iss_valid, 1);
    chk("mr_pre_rd", iss_rd, 80);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", iss_valid, 0);
    chk("mr_count", count, 0);
    chk("mr_rs1", iss_rs1_data, 0);
    chk("mr_rd", iss_rd, 0);
    chk("mr_ready", disp_ready, 1);
    #3 rst_n = 1'b1;
    step();
    chk("mr_after_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Reservation station directly upstream of the single-cycle integer ALU.
- Buffers renamed ALU/branch/jump micro-ops from dispatch and captures operand values from the writeback broadcast buses (wakeup).
- Every cycle, issues the oldest micro-op whose two source operands are both ready, driving the ALU's operand, control, rob_idx and rd inputs.
- Flushed wholesale on a redirect.

Parameters:
- DEPTH, 4, number of queue entries (power of two, ≥2)
- ROB_LEN, 16, ROB entries; ROB_IDX_W = $clog2(ROB_LEN)
- TAG_W, 7, physical register tag width (matches ALU rd width)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- disp_valid  in  1  dispatch offers a micro-op
- disp_ready  out  1  queue can accept a micro-op this cycle
- disp_opcode  in  5  opcode[6:2] (R/I/B/AUIPC/JAL/JALR/LUI encodings)
- disp_funct3  in  3  funct3
- disp_funct7  in  1  instruction bit 30
- disp_rs1_tag, disp_rs2_tag  in  TAG_W  source physical tags
- disp_rs1_rdy, disp_rs2_rdy  in  1  source value already available
- disp_rs1_data, disp_rs2_data  in  32  source values (valid when rdy)
- disp_imm  in  32  sign-extended immediate
- disp_pc  in  32  instruction PC
- disp_rob_idx  in  ROB_IDX_W  ROB slot
- disp_rd  in  TAG_W  destination physical tag
- wb0_valid, wb1_valid  in  1  writeback broadcast valid (port 0 = ALU, port 1 = LSU)
- wb0_tag, wb1_tag  in  TAG_W  broadcast destination tag
- wb0_data, wb1_data  in  32  broadcast value
- flush  in  1  redirect: discard all queued micro-ops
- iss_valid  out  1  to ALU alu_i_valid
- iss_opcode  out  5;  iss_funct3  out  3;  iss_funct7  out  1
- iss_rs1_data, iss_rs2_data, iss_imm, iss_pc  out  32
- iss_rob_idx  out  ROB_IDX_W;  iss_rd  out  TAG_W
- count  out  $clog2(DEPTH)+1  occupied entries (debug/perf)

Behaviour:
- Storage: compacting queue. Entry 0 is always oldest; valid entries are contiguous from index 0.
- Reset (rst_n low, asynchronous):
  - All entry valid bits clear and count = 0, so disp_ready = 1.
  - iss_valid = 0.
  - All iss_* data outputs = 0 (they are combinational from entry state and therefore 0 while empty).
- disp_ready:
  - Equals (count < DEPTH).
  - Does not look ahead at a same-cycle issue; a full queue refuses dispatch even when an issue frees a slot.
- Dispatch:
  - A micro-op is accepted when disp_valid && disp_ready && !flush.
  - It is written at the rising edge to index (count − issued_this_cycle), i.e. after compaction.
- Tag 0 (x0):
  - A source with tag 0 is marked ready with data 0 regardless of disp_rsN_rdy.
  - Broadcasts with tag 0 are ignored.
- Wakeup:
  - Each cycle, for each wb port with valid && tag ≠ 0: every valid entry with a not-ready source whose tag matches captures the data and sets ready at the edge.
  - Wakeup also applies to the micro-op being dispatched in the same cycle (dispatch bypass), so it enters the queue already ready.
  - If both ports match the same source, port 0 wins; this is legal only when tags alias, which must not occur.
- Select (combinational):
  - Lowest-index entry with valid && rs1_rdy && rs2_rdy.
  - iss_valid = found && !flush.
  - iss_* fields are driven from that entry.
  - When none is found, iss_valid = 0 and the data fields hold the entry-0 values (don't-care).
- Issue:
  - The ALU accepts unconditionally. The selected entry is removed at the edge.
  - Entries above it shift down by one; wakeups landing on shifting entries are applied to their new position.
- Latency:
  - A micro-op dispatched ready at edge E can be issued in the cycle after E (iss_valid high in cycle E+1).
  - A source woken by broadcast in cycle C becomes issuable in cycle C+1. There is no same-cycle broadcast-to-issue path.
- Throughput: one issue per cycle, one dispatch per cycle; simultaneous issue + dispatch keeps count constant.
- Flush:
  - At the edge, all entries are cleared and count = 0.
  - A dispatch offered in the flush cycle is dropped, and iss_valid is forced 0 in that cycle.
  - Wakeups in the flush cycle have no effect.
- Reset mid-operation: all entries are discarded immediately (asynchronous); there is no partial state.
- count: registered; updated as count + accepted_dispatch − issued, or 0 on flush.

Test Plan:
- Reset, then dispatch ADD (opcode R_TYPE, funct3 0, rs1=5, rs2=7, both rdy, rd=12, rob 3) → next cycle iss_valid=1, iss_rs1_data=5, iss_rs2_data=7, iss_rd=12, iss_rob_idx=3; following cycle count=0.
- Dispatch A (rs1 tag 20 not ready), then B (both ready) → B issues first. Then wb1_valid, tag 20, data 0x1234 → A issues the next cycle with iss_rs1_data=0x1234.
- Fill 4 non-ready entries → disp_ready=0, count=4. A wb0 wakeup of all four → issued on four consecutive cycles in age order; disp_ready returns to 1 after the first issue edge.
- Dispatch with rs2 tag 9 not ready in the same cycle as wb0 tag 9 data 0xCAFE → entry enters ready; iss_valid next cycle with iss_rs2_data=0xCAFE.
- Source tag 0 with disp_rs1_rdy=0 and disp_rs1_data=0xFFFF → issues immediately with iss_rs1_data=0; a wb broadcast to tag 0 changes no entry.
- 3 entries queued, flush asserted together with disp_valid and a matching wakeup → iss_valid=0 that cycle; next cycle count=0, iss_valid=0, disp_ready=1. rst_n pulsed low mid-stream → outputs zero immediately.
